// File: rtl/dff_arb_pkg.sv
// ---------------------------------------------------------------------------
// dff_arb_pkg
// Shared definitions for the shared-register arbiter slice.
//   NREQ    : default number of requesters (power of two; the round-robin
//             wrap relies on natural pointer overflow)
//   WIDTH   : default width of the shared register
//   state_t : arbiter FSM states
//     IDLE  : waiting for any request
//     WRITE : owner chosen, its data is loaded into the register
//     HOLD  : owner keeps the grant until it drops its request
// ---------------------------------------------------------------------------
package dff_arb_pkg;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector.
//   req    [NREQ-1:0] : pending requests
//   ptr    [PW-1:0]   : index holding highest priority this round
//   winner [NREQ-1:0] : one-hot winner, all-zero when req is zero
// Search order is ptr, ptr+1, ... wrapping modulo NREQ, so ptr-1 is the
// lowest priority.
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ = dff_arb_pkg::NREQ,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] winner
);

  logic [PW-1:0] idx;
  logic          found;

  // Walk the requesters starting at ptr; the PW-bit add wraps modulo NREQ
  // because NREQ is a power of two. First hit wins, the rest are masked.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + i[PW-1:0];
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// ---------------------------------------------------------------------------
// dff_bank_arbiter
// Round-robin arbiter in front of one shared D-flip-flop register. A winning
// requester gets a grant, its data slice is written into q on the following
// edge together with a one-cycle ack, and the grant is held until the
// requester lowers its request.
//   clk                      : clock, rising edge
//   rst                      : synchronous active-high reset
//   req     [NREQ-1:0]       : level write requests, held until ack
//   data_in [NREQ*WIDTH-1:0] : write data, requester i in [i*WIDTH +: WIDTH]
//   grant   [NREQ-1:0]       : registered one-hot owner
//   ack     [NREQ-1:0]       : registered one-hot write-complete pulse
//   q       [WIDTH-1:0]      : shared register contents
//   busy                     : high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module dff_bank_arbiter #(
  parameter int NREQ  = dff_arb_pkg::NREQ,
  parameter int WIDTH = dff_arb_pkg::WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_in,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
);

  import dff_arb_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] pick;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick)
  );

  function automatic logic [PW-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) r = i[PW-1:0];
    end
    return r;
  endfunction

  assign busy = (state != IDLE);

  // Arbiter FSM plus the shared register. The winner index is captured at
  // grant time so WRITE and HOLD never look at the selector again; requests
  // from other requesters are ignored until the FSM is back in IDLE.
  // ack defaults low every cycle so it can only ever be a single pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      win_idx <= '0;
      grant   <= '0;
      ack     <= '0;
      q       <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant   <= pick;
            win_idx <= onehot_to_idx(pick);
            state   <= WRITE;
          end
        end
        WRITE: begin
          q     <= data_in[win_idx*WIDTH +: WIDTH];
          ack   <= grant;
          state <= HOLD;
        end
        HOLD: begin
          if (!req[win_idx]) begin
            grant <= '0;
            ptr   <= win_idx + 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dff_bank_arbiter
// Scoreboard bench for dff_bank_arbiter: each directed scenario pushes the
// writes it expects (ack bit and q value, in arbitration order) and a
// negedge monitor pops one entry per observed ack.
// ---------------------------------------------------------------------------
module tb_dff_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  typedef struct {
    logic [NREQ-1:0]  ack;
    logic [WIDTH-1:0] q;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic                  busy;

  exp_t sb[$];
  int   assertions = 0;
  int   failures   = 0;

  dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data_in (data_in),
    .grant   (grant),
    .ack     (ack),
    .q       (q),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d);
    req     = r;
    data_in = d;
  endtask

  task automatic pushExp(input int idx, input logic [WIDTH-1:0] val);
    exp_t e;
    e.ack = '0;
    e.ack[idx] = 1'b1;
    e.q = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitGrant(input logic [NREQ-1:0] exp, input string tag);
    for (int n = 0; n < 20; n++) begin
      tick();
      if (grant != '0) break;
    end
    checkOutput(tag, grant, exp);
  endtask

  task automatic waitAckAndDrop(input int idx, input string tag);
    for (int n = 0; n < 20; n++) begin
      tick();
      if (ack[idx]) break;
    end
    checkOutput(tag, ack[idx], 1);
    req[idx] = 1'b0;
  endtask

  // Monitor: every ack must match the next scoreboard entry, and grant/ack
  // must stay one-hot (or zero) in every cycle.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("grant_onehot", $onehot0(grant), 1);
      checkOutput("ack_onehot", $onehot0(ack), 1);
      if (ack != '0) begin
        if (sb.size() == 0) begin
          checkOutput("ack_unexpected", ack, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("sb_ack", ack, e.ack);
          checkOutput("sb_q", q, e.q);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus('0, '0);
    rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_q", q, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;

    // Contention from ptr=0: all four request, each drops after its ack.
    $display("[TB] contention");
    applyStimulus(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11});
    pushExp(0, 8'h11); pushExp(1, 8'h22); pushExp(2, 8'h33); pushExp(3, 8'h44);
    for (int i = 0; i < NREQ; i++) begin
      waitGrant(4'b0001 << i, "cont_grant");
      waitAckAndDrop(i, "cont_ack");
    end
    tick();
    checkOutput("cont_release", grant, 0);

    // Single request with exact latency checks; ptr is 0 after winner 3.
    $display("[TB] single request");
    applyStimulus(4'b0001, {8'h00, 8'h00, 8'h00, 8'hA5});
    pushExp(0, 8'hA5);
    tick();
    checkOutput("single_grant", grant, 4'b0001);
    checkOutput("single_busy", busy, 1);
    checkOutput("single_noack", ack, 0);
    tick();
    checkOutput("single_ack", ack, 4'b0001);
    checkOutput("single_q", q, 8'hA5);
    req = '0;
    tick();
    checkOutput("single_release", grant, 0);
    checkOutput("single_idle", busy, 0);
    checkOutput("single_ack_done", ack, 0);

    // ptr must now be 1: requester 1 beats requester 0, then 0 follows.
    $display("[TB] pointer advance");
    applyStimulus(4'b0011, {8'h00, 8'h00, 8'h5B, 8'h6C});
    pushExp(1, 8'h5B); pushExp(0, 8'h6C);
    waitGrant(4'b0010, "ptr1_grant");
    waitAckAndDrop(1, "ptr1_ack");
    waitGrant(4'b0001, "ptr1_next");
    waitAckAndDrop(0, "ptr1_ack0");

    // Winner 2 leaves ptr at 3, then 1001 wraps: 3 first, then 0.
    $display("[TB] wrap");
    applyStimulus(4'b0100, {8'h00, 8'h77, 8'h00, 8'h00});
    pushExp(2, 8'h77);
    waitGrant(4'b0100, "pre_wrap_grant");
    waitAckAndDrop(2, "pre_wrap_ack");
    tick();
    applyStimulus(4'b1001, {8'hD3, 8'h00, 8'h00, 8'hE4});
    pushExp(3, 8'hD3); pushExp(0, 8'hE4);
    waitGrant(4'b1000, "wrap_grant3");
    waitAckAndDrop(3, "wrap_ack3");
    waitGrant(4'b0001, "wrap_grant0");
    waitAckAndDrop(0, "wrap_ack0");
    tick();
    checkOutput("wrap_release", grant, 0);

    // Early drop: req[2] falls during WRITE, write still lands.
    $display("[TB] early drop");
    applyStimulus(4'b0100, {8'h00, 8'h5A, 8'h00, 8'h00});
    pushExp(2, 8'h5A);
    tick();
    checkOutput("early_grant", grant, 4'b0100);
    req = '0;
    tick();
    checkOutput("early_ack", ack, 4'b0100);
    checkOutput("early_q", q, 8'h5A);
    tick();
    checkOutput("early_release", grant, 0);
    checkOutput("early_idle", busy, 0);

    // Reset during WRITE: no ack, q cleared, ptr back to 0.
    $display("[TB] reset mid-op");
    applyStimulus(4'b0010, {8'h00, 8'h00, 8'h3C, 8'h00});
    tick();
    checkOutput("rstop_grant", grant, 4'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = '0;
    checkOutput("rstop_q", q, 0);
    checkOutput("rstop_ack", ack, 0);
    checkOutput("rstop_grant0", grant, 0);
    checkOutput("rstop_busy", busy, 0);
    tick();
    checkOutput("rstop_noack", ack, 0);
    applyStimulus(4'b0011, {8'h00, 8'h00, 8'h81, 8'h92});
    pushExp(0, 8'h92); pushExp(1, 8'h81);
    waitGrant(4'b0001, "rstop_ptr0");
    waitAckAndDrop(0, "rstop_ack0");
    waitGrant(4'b0010, "rstop_next");
    waitAckAndDrop(1, "rstop_ack1");
    tick();

    // Idle stability: nothing may move with no requests.
    $display("[TB] idle stability");
    applyStimulus('0, {8'hFF, 8'hFF, 8'hFF, 8'hFF});
    for (int n = 0; n < 10; n++) begin
      tick();
      checkOutput("idle_q", q, 8'h81);
      checkOutput("idle_grant", grant, 0);
      checkOutput("idle_ack", ack, 0);
      checkOutput("idle_busy", busy, 0);
    end

    checkOutput("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
